// File: rtl/pk_pkg.sv
// Shared constants and helpers for the Pass-Keeper vault.
// Provides the block/round/store sizes, the FSM state type, the AES S-box
// lookup, the Rcon schedule and the GF(2^8) doubling used by MixColumns.
package pk_pkg;

  localparam int BLOCK_W     = 128;
  localparam int NROUNDS     = 10;
  localparam int STORE_DEPTH = 16;

  typedef logic [0:0] pk_state_t;
  localparam pk_state_t IDLE = 1'b0;
  localparam pk_state_t RUN  = 1'b1;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for round r (1..10); unused indices return zero.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_round.sv
// Combinational AES-128 encryption round with on-the-fly key expansion.
// Ports: state_i (state after previous AddRoundKey), rkey_i (previous round
// key), rcon_i (round constant for this round), last_i (skip MixColumns),
// state_o (state after this round), rkey_o (this round's key).
module aes128_round
  import pk_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  input  logic [7:0]   rcon_i,
  input  logic         last_i,
  output logic [127:0] state_o,
  output logic [127:0] rkey_o
);

  logic [31:0] temp_s;
  logic [7:0]  in_b  [16];
  logic [7:0]  sr_b  [16];
  logic [7:0]  mc_b  [16];

  // Next round key: w0 is the most significant word of the key.
  always_comb begin
    temp_s = {sbox(rkey_i[23:16]), sbox(rkey_i[15:8]), sbox(rkey_i[7:0]), sbox(rkey_i[31:24])}
             ^ {rcon_i, 24'h000000};
    rkey_o[127:96] = rkey_i[127:96] ^ temp_s;
    rkey_o[95:64]  = rkey_i[95:64]  ^ rkey_o[127:96];
    rkey_o[63:32]  = rkey_i[63:32]  ^ rkey_o[95:64];
    rkey_o[31:0]   = rkey_i[31:0]   ^ rkey_o[63:32];
  end

  // SubBytes + ShiftRows; byte index is 4*column + row, byte 0 at the MSB.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      in_b[i] = state_i[127-8*i -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_b[4*c+r] = sbox(in_b[4*((c+r)%4)+r]);
      end
    end
  end

  // MixColumns on each column, then AddRoundKey (MixColumns bypassed in round 10).
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc_b[4*c+0] = xtime(sr_b[4*c]) ^ xtime(sr_b[4*c+1]) ^ sr_b[4*c+1] ^ sr_b[4*c+2] ^ sr_b[4*c+3];
      mc_b[4*c+1] = sr_b[4*c] ^ xtime(sr_b[4*c+1]) ^ xtime(sr_b[4*c+2]) ^ sr_b[4*c+2] ^ sr_b[4*c+3];
      mc_b[4*c+2] = sr_b[4*c] ^ sr_b[4*c+1] ^ xtime(sr_b[4*c+2]) ^ xtime(sr_b[4*c+3]) ^ sr_b[4*c+3];
      mc_b[4*c+3] = xtime(sr_b[4*c]) ^ sr_b[4*c] ^ sr_b[4*c+1] ^ sr_b[4*c+2] ^ xtime(sr_b[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      if (last_i) begin
        state_o[127-8*i -: 8] = sr_b[i] ^ rkey_o[127-8*i -: 8];
      end else begin
        state_o[127-8*i -: 8] = mc_b[i] ^ rkey_o[127-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/pass_keeper_wrapper.sv
// Pass-Keeper vault top: AES-128 encrypts a password under
// (master_key XOR account), one round per cycle, and logs every ciphertext
// into a 16-entry circular store whose wrap point is max_address.
// Ports: clk, rst (sync, active-high), go (start, sampled in IDLE),
// master_key/account/password (128-bit inputs), max_address (last store
// index), done (one-cycle completion pulse), password_enc (last ciphertext).
module pass_keeper_wrapper
  import pk_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [127:0] master_key,
  input  logic [127:0] account,
  input  logic [127:0] password,
  input  logic [3:0]   max_address,
  output logic         done,
  output logic [127:0] password_enc
);

  pk_state_t    fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic         done_q, done_d;
  logic [127:0] enc_q, enc_d;
  logic [3:0]   wptr_q, wptr_d;
  logic [127:0] store_q [STORE_DEPTH];
  logic [127:0] store_d [STORE_DEPTH];

  logic [127:0] rnd_state_s;
  logic [127:0] rnd_key_s;
  logic         last_s;

  assign last_s = (round_q == 4'(NROUNDS));

  aes128_round u_round (
    .state_i (state_q),
    .rkey_i  (key_q),
    .rcon_i  (rcon(round_q)),
    .last_i  (last_s),
    .state_o (rnd_state_s),
    .rkey_o  (rnd_key_s)
  );

  // Next-state logic: latch on go in IDLE, one round per cycle in RUN.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    key_d   = key_q;
    done_d  = 1'b0;
    enc_d   = enc_q;
    wptr_d  = wptr_q;
    store_d = store_q;
    case (fsm_q)
      IDLE: begin
        if (go) begin
          key_d   = master_key ^ account;
          state_d = password ^ master_key ^ account;
          round_d = 4'd1;
          fsm_d   = RUN;
        end else begin
          fsm_d = IDLE;
        end
      end
      RUN: begin
        state_d = rnd_state_s;
        key_d   = rnd_key_s;
        if (last_s) begin
          fsm_d           = IDLE;
          round_d         = 4'd0;
          done_d          = 1'b1;
          enc_d           = rnd_state_s;
          store_d[wptr_q] = rnd_state_s;
          // >= rather than == so lowering max_address below wptr still wraps.
          wptr_d          = (wptr_q >= max_address) ? 4'd0 : wptr_q + 4'd1;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: begin
        fsm_d   = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // State registers with synchronous reset; reset also aborts a running operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      state_q <= 128'd0;
      key_q   <= 128'd0;
      done_q  <= 1'b0;
      enc_q   <= 128'd0;
      wptr_q  <= 4'd0;
      for (int i = 0; i < STORE_DEPTH; i++) begin
        store_q[i] <= 128'd0;
      end
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      key_q   <= key_d;
      done_q  <= done_d;
      enc_q   <= enc_d;
      wptr_q  <= wptr_d;
      store_q <= store_d;
    end
  end

  assign done         = done_q;
  assign password_enc = enc_q;

endmodule

// File: tb/tb_pass_keeper_wrapper.sv
// Self-checking bench for pass_keeper_wrapper: expected ciphertexts are
// queued when an operation is launched and compared when done pulses.
module tb_pass_keeper_wrapper;

  localparam logic [127:0] FIPS_KEY = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] FIPS_PT  = 128'h54776F204F6E65204E696E652054776F;
  localparam logic [127:0] FIPS_CT  = 128'h29C3505F571420F6402299B31A02D73A;
  localparam logic [127:0] ZERO_CT  = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
  localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         go;
  logic [127:0] master_key;
  logic [127:0] account;
  logic [127:0] password;
  logic [3:0]   max_address;
  logic         done;
  logic [127:0] password_enc;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_q [$];
  logic [3:0]   ewptr;

  pass_keeper_wrapper dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .master_key   (master_key),
    .account      (account),
    .password     (password),
    .max_address  (max_address),
    .done         (done),
    .password_enc (password_enc)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Launch one operation; returns just after the go-sampling edge with
  // the inputs scrambled so a late change would corrupt the result.
  task automatic start_op(input logic [127:0] mk, input logic [127:0] acct,
                          input logic [127:0] pw, input logic [127:0] expv);
    @(negedge clk);
    master_key = mk;
    account    = acct;
    password   = pw;
    go         = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    go         = 1'b0;
    master_key = {$urandom, $urandom, $urandom, $urandom};
    account    = {$urandom, $urandom, $urandom, $urandom};
    password   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Wait (bounded) for done, check latency, ciphertext, pulse width and wptr.
  task automatic finish_op(input string tag, input int exp_lat);
    int lat = 0;
    logic [127:0] expv;
    while (done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 128'd0;
    if (done === 1'b1) begin
      check_val({tag, "_enc"}, password_enc, expv);
      ewptr = (ewptr >= max_address) ? 4'd0 : ewptr + 4'd1;
      @(negedge clk);
      check_val({tag, "_done_fall"}, 128'(done), 128'd0);
      check_val({tag, "_wptr"}, 128'(dut.wptr_q), 128'(ewptr));
    end
  endtask

  // Count done pulses over a window of cycles.
  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; go = 1'b0; max_address = 4'd15;
    master_key = 128'd0; account = 128'd0; password = 128'd0;
    ewptr = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_val("rst_done", 128'(done), 128'd0);
    check_val("rst_enc", password_enc, 128'd0);
    check_val("rst_wptr", 128'(dut.wptr_q), 128'd0);
    check_val("rst_store5", dut.store_q[5], 128'd0);

    start_op(FIPS_KEY, 128'd0, FIPS_PT, FIPS_CT);
    finish_op("fips", 10);

    start_op(FIPS_KEY, FIPS_KEY, 128'd0, ZERO_CT);
    finish_op("tweak", 10);

    // Second go five rounds into RUN must be ignored.
    start_op(C1_KEY, 128'd0, C1_PT, C1_CT);
    repeat (4) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    finish_op("ign_go", 5);
    count_done(15, n);
    check_val("ign_go_extra", 128'(n), 128'd0);

    start_op(FIPS_KEY, 128'd0, FIPS_PT, FIPS_CT);
    finish_op("fips_rep", 10);
    check_val("store1", dut.store_q[1], ZERO_CT);

    // Reset and go together: reset wins.
    @(negedge clk);
    rst = 1'b1; go = 1'b1; master_key = FIPS_KEY; password = FIPS_PT; account = 128'd0;
    @(negedge clk);
    rst = 1'b0; go = 1'b0;
    ewptr = 4'd0;
    count_done(14, n);
    check_val("rstgo_done", 128'(n), 128'd0);
    check_val("rstgo_enc", password_enc, 128'd0);

    // Wrap with max_address = 1: entries 0, 1, 0.
    max_address = 4'd1;
    start_op(FIPS_KEY, 128'd0, FIPS_PT, FIPS_CT);
    finish_op("wrap0", 10);
    start_op(C1_KEY, C1_KEY, 128'd0, ZERO_CT);
    finish_op("wrap1", 10);
    start_op(C1_KEY, 128'd0, C1_PT, C1_CT);
    finish_op("wrap2", 10);
    check_val("wrap_st0", dut.store_q[0], C1_CT);
    check_val("wrap_st1", dut.store_q[1], ZERO_CT);
    check_val("wrap_st2", dut.store_q[2], 128'd0);
    check_val("wrap_wptr", 128'(dut.wptr_q), 128'd1);

    // Reset at round 6 aborts the operation.
    start_op(FIPS_KEY, 128'd0, FIPS_PT, FIPS_CT);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    ewptr = 4'd0;
    check_val("abort_enc", password_enc, 128'd0);
    check_val("abort_wptr", 128'(dut.wptr_q), 128'd0);
    count_done(14, n);
    check_val("abort_done", 128'(n), 128'd0);
    check_val("abort_st0", dut.store_q[0], 128'd0);

    start_op(FIPS_KEY, 128'd0, FIPS_PT, FIPS_CT);
    finish_op("post_abort", 10);
    check_val("post_abort_st0", dut.store_q[0], FIPS_CT);
    check_val("queue_empty", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
